// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_reg;
   logic             pop_ok;
   logic             push_ok;

   // A pop accepted while full frees the slot the same-cycle push lands in.
   assign pop_ok  = pop & (count_reg != '0);
   assign push_ok = push & ((count_reg != FULL_COUNT) | pop_ok);

   assign count = count_reg;
   assign empty = (count_reg == '0);
   assign full  = (count_reg == FULL_COUNT);

   // Storage is kept out of reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (rstn && push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_reg  <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         dout_valid <= pop_ok;
         count_reg  <= count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
         overflow   <= push & ~push_ok;
         underflow  <= pop & ~pop_ok;
      end
   end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Synchronous first-in/first-out buffer: the read-from-the-other-end counterpart of the team's LIFO stack block.
- Data is written at the tail and read from the head in arrival order.
- Used wherever producer/consumer ordering must be preserved, e.g. between the stack-based datapath and downstream serial/output logic.
- Single clock domain; registered read data; flags with per-cycle overflow/underflow pulses.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two, >= 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- push  input  1  write request; din captured at clk edge if accepted.
- pop  input  1  read request; head entry presented on dout next cycle if accepted.
- din  input  WIDTH  write data.
- dout  output  WIDTH  registered read data; holds last popped value until next accepted pop.
- dout_valid  output  1  one-cycle pulse, high the cycle after an accepted pop.
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- overflow  output  1  one-cycle pulse: push rejected previous cycle.
- underflow  output  1  one-cycle pulse: pop rejected previous cycle.

Behaviour:
- Reset: rstn is synchronous, active-low, clock is clk; sampled at rising edge of clk.
  - While low: wr_ptr = 0, rd_ptr = 0, count = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Therefore empty = 1, full = 0.
  - Storage array contents are not reset.
  - Reset asserted mid-operation discards all stored entries; push/pop in that cycle are ignored.
- Acceptance, evaluated on registered state at the clock edge:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok). When full, a simultaneous accepted pop frees the slot in the same cycle.
  - When empty, push & pop: push accepted, pop rejected (no fall-through), underflow pulses, count becomes 1.
- Write: on push_ok, mem[wr_ptr] <= din; wr_ptr <= wr_ptr + 1 (wraps modulo DEPTH).
- Read: on pop_ok, dout <= mem[rd_ptr]; rd_ptr <= rd_ptr + 1 (wraps); dout_valid <= 1, otherwise 0.
  - Read latency is 1 cycle from pop sample to dout/dout_valid.
  - dout is not changed by rejected pops.
- Count update:
  - count <= count + push_ok - pop_ok.
  - Both accepted: count unchanged, pointers both advance.
- Flags:
  - empty and full are combinational from count.
  - overflow <= push & !push_ok.
  - underflow <= pop & !pop_ok.
  - Both pulse for exactly one cycle per rejected request and never change FIFO state.
- Ordering: data popped in the same order it was accepted, across any number of pointer wraps.
- No combinational path from push/pop/din to any output.

Test Plan:
- Reset, then push 8'h? values 1,2,3,4,5,6,7,8 (WIDTH=4, DEPTH=8) on 8 cycles -> count steps 1..8, full=1 after 8th edge, empty=0.
- From full, push 9 alone -> overflow pulses 1 cycle, count stays 8, later pops return 1..8 only.
- From full, push 9 with pop same cycle -> no overflow, count stays 8, dout=1 with dout_valid next cycle; draining returns 2..9.
- Push 1..8, pop 8, push A,B,C, pop 3 -> pointers wrap, dout sequence 1..8 then A,B,C, empty=1 at end.
- Empty FIFO, pop alone -> underflow pulse, dout unchanged, count 0.
- Empty FIFO, push 5 with pop -> underflow pulse, count 1; next pop returns 5.
- Fill 5 entries, assert rstn=0 one cycle together with push and pop -> count=0, empty=1, dout=0, no flag pulses; next pop -> underflow.
